gen_sequencer: RTL
==================

GEN_SEQUENCER -- requirements
Module: gen_sequencer

Interface
REQ-001 Parameter: WIDTH, default 64, grid width in cells (one bit per cell).
REQ-002 Parameter: CNT_W, default 16, generation counter width.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: clr  input  1  one-cycle strobe; zero the grid and return to idle.
REQ-006 Port: load  input  1  one-cycle strobe; capture seed into the grid.
REQ-007 Port: seed  input  WIDTH  initial grid pattern.
REQ-008 Port: run  input  1  level; free-running evolution while high.
REQ-009 Port: step  input  1  one-cycle strobe; advance exactly one generation.
REQ-010 Port: halt_en  input  1  level; enables the stable and extinct stop conditions.
REQ-011 Port: rate  input  8  generation period minus 1, in clk cycles.
REQ-012 Port: gen_limit  input  CNT_W  generation stop count; 0 disables the limit.
REQ-013 Port: dp_next  input  WIDTH  next-generation grid from the datapath, combinational from dp_grid.
REQ-014 Port: dp_grid  output  WIDTH  current grid register, driven to the datapath input.
REQ-015 Port: gen_count  output  CNT_W  generations committed since the last load, clr or reset.
REQ-016 Port: busy  output  1  high in RUN or STEP.
REQ-017 Port: done  output  1  one-cycle pulse on entry to HALT.
REQ-018 Port: halt_cause  output  2  00 none, 01 stable, 10 extinct, 11 limit.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, STEP and HALT; the encoding is free.
REQ-020 Command priority SHALL be reset > clr > load > run/step.
REQ-021 clr, in any state, SHALL set grid=0, gen_count=0, prescaler=0, halt_cause=00 and state=IDLE on the next edge.
REQ-022 load, in any state, SHALL set grid=seed, gen_count=0, prescaler=0, halt_cause=00 and state=IDLE on the next edge.
REQ-023 IDLE SHALL go to RUN when run=1 (step is ignored in that case), go to STEP when run=0 and step=1, and otherwise hold.
REQ-024 In RUN the prescaler SHALL increment each cycle; when prescaler==rate, a tick SHALL occur and the prescaler SHALL reload to 0.
REQ-025 rate=0 SHALL give one tick per cycle; rate=N SHALL give one tick every N+1 cycles.
REQ-026 In RUN, run=0 SHALL move the FSM to IDLE on the next edge with the prescaler cleared and no tick in that cycle.
REQ-027 STEP SHALL last exactly one cycle, tick unconditionally (ignoring rate), and then go to IDLE unless a halt condition fires.
REQ-028 A step strobe in RUN or HALT SHALL be ignored.
REQ-029 On a tick, grid SHALL take dp_next and gen_count SHALL increment.
REQ-030 gen_count SHALL saturate at all-ones; ticks at saturation SHALL still update the grid.
REQ-031 Halt conditions SHALL be evaluated on the tick cycle using pre-tick values:
  - limit: gen_limit!=0 and gen_count+1==gen_limit
  - extinct: halt_en=1 and dp_next==0
  - stable: halt_en=1 and dp_next==grid
REQ-032 Halt priority SHALL be limit > extinct > stable; the tick still commits, and the FSM enters HALT on the same edge with halt_cause set.
REQ-033 done SHALL be high for exactly the first cycle in HALT.
REQ-034 HALT SHALL be left only by load, clr or reset; run and step SHALL be ignored in HALT.
REQ-035 dp_grid SHALL equal the grid register at all times, with no combinational path from dp_next.
REQ-036 busy SHALL be a registered-state decode: high iff state is RUN or STEP.

Reset
REQ-037 reset SHALL be synchronous to clk and active-high.
REQ-038 On reset: grid=0, gen_count=0, prescaler=0, halt_cause=00, done=0, busy=0, state=IDLE, in any state including mid-RUN.

Verification
REQ-039 The bench SHALL pair the block with a behavioural 8x8 next-generation model on dp_next and cover:
  - Step: load seed=0x0000000000000700 (blinker), then a step pulse -> busy high for 1 cycle; grid=0x0000000000020202; gen_count=1; state IDLE.
  - Rate: rate=3, run held for 20 cycles -> ticks on cycles 4,8,12,16,20; gen_count=5.
  - Stable halt: halt_en=1, seed=0x0000000000000303 (block), run=1 -> first tick enters HALT; halt_cause=01; done pulse; gen_count=1; run ignored afterwards.
  - Limit halt: gen_limit=3, rate=0, halt_en=0, blinker, run=1 -> HALT after 3 ticks; halt_cause=11; gen_count=3.
  - Extinct: seed=0x0000000000000001, halt_en=1, step -> HALT; halt_cause=10; grid=0.
  - Priority and reset: clr and load in the same cycle -> grid=0; load mid-RUN -> IDLE with grid=seed; reset mid-RUN -> all outputs zero on the next edge.

Source files
------------

// File: rtl/gen_sequencer.sv
// Generation sequencer: owns the cellular-automaton grid register, paces
// generations from run/step commands and stops on stable, extinct or limit.
module gen_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             run,
  input  logic             step,
  input  logic             halt_en,
  input  logic [7:0]       rate,
  input  logic [CNT_W-1:0] gen_limit,
  input  logic [WIDTH-1:0] dp_next,
  output logic [WIDTH-1:0] dp_grid,
  output logic [CNT_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       halt_cause
);

  localparam int unsigned PRE_W = 8;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_STABLE  = 2'b01;
  localparam logic [1:0] CAUSE_EXTINCT = 2'b10;
  localparam logic [1:0] CAUSE_LIMIT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] grid_q;
  logic [CNT_W-1:0] gen_count_q;
  logic [PRE_W-1:0] presc_q;
  logic [1:0]       halt_cause_q;
  logic             done_q;
  logic             busy_q;

  logic [CNT_W-1:0] gen_inc_d;
  logic [CNT_W-1:0] gen_count_d;
  logic             rate_hit_d;
  logic [1:0]       cause_d;

  // Next generation count and halt cause, evaluated from pre-tick values
  always_comb begin
    gen_inc_d   = gen_count_q + CNT_W'(1);
    gen_count_d = (&gen_count_q) ? gen_count_q : gen_inc_d;
    rate_hit_d  = (presc_q == rate);
    cause_d     = CAUSE_NONE;
    if ((gen_limit != '0) && (gen_inc_d == gen_limit)) begin
      cause_d = CAUSE_LIMIT;
    end else if (halt_en && (dp_next == '0)) begin
      cause_d = CAUSE_EXTINCT;
    end else if (halt_en && (dp_next == grid_q)) begin
      cause_d = CAUSE_STABLE;
    end
  end

  // Sequencer FSM with grid, counter, prescaler and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grid_q       <= '0;
      gen_count_q  <= '0;
      presc_q      <= '0;
      halt_cause_q <= CAUSE_NONE;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else if (clr || load) begin
      state_q      <= S_IDLE;
      grid_q       <= clr ? '0 : seed;
      gen_count_q  <= '0;
      presc_q      <= '0;
      halt_cause_q <= CAUSE_NONE;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          if (run) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else if (step) begin
            state_q <= S_STEP;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!run) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            presc_q <= '0;
          end else if (rate_hit_d) begin
            grid_q      <= dp_next;
            gen_count_q <= gen_count_d;
            presc_q     <= '0;
            if (cause_d != CAUSE_NONE) begin
              state_q      <= S_HALT;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              halt_cause_q <= cause_d;
            end
          end else begin
            presc_q <= presc_q + PRE_W'(1);
          end
        end
        S_STEP: begin
          grid_q      <= dp_next;
          gen_count_q <= gen_count_d;
          busy_q      <= 1'b0;
          if (cause_d != CAUSE_NONE) begin
            state_q      <= S_HALT;
            done_q       <= 1'b1;
            halt_cause_q <= cause_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALT: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dp_grid    = grid_q;
  assign gen_count  = gen_count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign halt_cause = halt_cause_q;

endmodule
